// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART widths and default receive FIFO depth
package uart_pkg;
   localparam int UART_DATA_W        = 8;
   localparam int UART_RX_FIFO_DEPTH = 16;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receive-byte write strobe, show-ahead read side and status of the RX FIFO
interface uart_rx_fifo_if import uart_pkg::*; #(
   parameter int DEPTH = UART_RX_FIFO_DEPTH
) ();
   logic [UART_DATA_W-1:0]     rx_data;
   logic                       rx_done;
   logic [UART_DATA_W-1:0]     rd_data;
   logic                       rd_valid;
   logic                       rd_ready;
   logic [$clog2(DEPTH):0]     count;
   logic                       overrun;
   logic                       overrun_clr;

   modport master (
      output rx_data, rx_done, rd_ready, overrun_clr,
      input  rd_data, rd_valid, count, overrun
   );

   modport slave (
      input  rx_data, rx_done, rd_ready, overrun_clr,
      output rd_data, rd_valid, count, overrun
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - show-ahead byte FIFO behind a UART receiver with sticky overrun flag
module uart_rx_fifo import uart_pkg::*; #(
   parameter int DEPTH = UART_RX_FIFO_DEPTH
) (
   input  logic          clk,
   input  logic          rst,
   uart_rx_fifo_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [UART_DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]       head_q, head_d;
   logic [PTR_W-1:0]       tail_q, tail_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   overrun_q, overrun_d;
   logic                   empty, full, pop, push, drop;

   always_comb begin
      empty     = (count_q == '0);
      full      = (count_q == CNT_W'(DEPTH));
      pop       = !empty && bus.rd_ready;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      push      = bus.rx_done && (!full || pop);
      drop      = bus.rx_done && !push;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      overrun_d = overrun_q;
      if (pop) begin
         head_d = head_q + PTR_W'(1);
      end
      if (push) begin
         tail_d = tail_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      // A new drop outranks a clear request in the same cycle.
      if (drop) begin
         overrun_d = 1'b1;
      end else if (bus.overrun_clr) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_q[tail_q] <= bus.rx_data;
      end
   end

   assign bus.rd_data  = empty ? '0 : mem_q[head_q];
   assign bus.rd_valid = !empty;
   assign bus.count    = count_q;
   assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - queue-model checked bench for uart_rx_fifo
module tb_uart_rx_fifo;
   localparam int DEPTH = 16;

   logic clk;
   logic rst;
   uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

   uart_rx_fifo #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int   checks   = 0;
   int   failures = 0;
   bit   cmp_en   = 0;
   logic [7:0] mq[$];
   bit   m_ov     = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0d (0x%0h) expected %0d (0x%0h)", name, $time, act, act, exp, exp);
      end
   endtask

   // Drive one cycle of inputs, advance the reference queue model at the edge, return at the falling edge.
   task automatic cyc(input bit d, input logic [7:0] b, input bit rr, input bit clr);
      bit pop, acc, drop;
      bus.rx_done     = d;
      bus.rx_data     = b;
      bus.rd_ready    = rr;
      bus.overrun_clr = clr;
      @(posedge clk);
      drop = 0;
      if (rst) begin
         mq.delete();
         m_ov = 0;
      end else begin
         pop = (mq.size() > 0) && rr;
         acc = (mq.size() < DEPTH) || pop;
         if (pop) void'(mq.pop_front());
         if (d) begin
            if (acc) mq.push_back(b);
            else drop = 1;
         end
         if (drop) m_ov = 1;
         else if (clr) m_ov = 0;
      end
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("rd_valid", int'(bus.rd_valid), int'(mq.size() != 0));
         chk("count", int'(bus.count), mq.size());
         chk("overrun", int'(bus.overrun), int'(m_ov));
         if (mq.size() != 0) chk("rd_data", int'(bus.rd_data), int'(mq[0]));
      end
   end

   initial begin
      logic [7:0] seq3 [3];
      seq3[0] = 8'hA5; seq3[1] = 8'h3C; seq3[2] = 8'hFF;
      rst = 1'b1;
      bus.rx_done = 0; bus.rx_data = '0; bus.rd_ready = 0; bus.overrun_clr = 0;
      cyc(0, 8'h00, 0, 0);
      cyc(0, 8'h00, 0, 0);
      rst = 1'b0;
      chk("reset_count", int'(bus.count), 0);
      chk("reset_rd_valid", int'(bus.rd_valid), 0);
      chk("reset_rd_data", int'(bus.rd_data), 8'h00);
      chk("reset_overrun", int'(bus.overrun), 0);
      cmp_en = 1;

      // Three writes then drain.
      for (int i = 0; i < 3; i++) cyc(1, seq3[i], 0, 0);
      chk("seq3_count", int'(bus.count), 3);
      for (int i = 0; i < 3; i++) begin
         chk("seq3_data", int'(bus.rd_data), int'(seq3[i]));
         chk("seq3_cnt", int'(bus.count), 3 - i);
         cyc(0, 8'h00, 1, 0);
      end
      chk("seq3_empty", int'(bus.rd_valid), 0);
      chk("seq3_count0", int'(bus.count), 0);
      cyc(0, 8'h00, 1, 0);
      chk("idle_pop_count", int'(bus.count), 0);

      // Fill, overflow with 99, drain.
      for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0);
      chk("full_count", int'(bus.count), 16);
      cyc(1, 8'h99, 0, 0);
      chk("ovf_count", int'(bus.count), 16);
      chk("ovf_flag", int'(bus.overrun), 1);
      for (int i = 0; i < 16; i++) begin
         chk("ovf_data", int'(bus.rd_data), i);
         cyc(0, 8'h00, 1, 0);
      end
      chk("ovf_empty", int'(bus.rd_valid), 0);
      cyc(0, 8'h00, 0, 1);
      chk("ovf_clr", int'(bus.overrun), 0);

      // Full FIFO, write and pop together.
      for (int i = 0; i < 16; i++) cyc(1, 8'(8'h40 + i), 0, 0);
      cyc(1, 8'h77, 1, 0);
      chk("fullrw_count", int'(bus.count), 16);
      chk("fullrw_ovr", int'(bus.overrun), 0);
      chk("fullrw_head", int'(bus.rd_data), 8'h41);
      for (int i = 0; i < 15; i++) cyc(0, 8'h00, 1, 0);
      chk("fullrw_last", int'(bus.rd_data), 8'h77);
      cyc(0, 8'h00, 1, 0);
      chk("fullrw_empty", int'(bus.count), 0);

      // Single entry, simultaneous write and pop.
      cyc(1, 8'h11, 0, 0);
      cyc(1, 8'h22, 1, 0);
      chk("rw1_count", int'(bus.count), 1);
      chk("rw1_data", int'(bus.rd_data), 8'h22);
      cyc(0, 8'h00, 1, 0);

      // Set beats clear.
      for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0);
      cyc(1, 8'hAA, 0, 0);
      chk("ovr_set", int'(bus.overrun), 1);
      cyc(1, 8'hBB, 0, 1);
      chk("ovr_set_wins", int'(bus.overrun), 1);
      cyc(0, 8'h00, 0, 1);
      chk("ovr_clr_alone", int'(bus.overrun), 0);

      // Reset with active inputs discards contents.
      rst = 1'b1;
      cyc(1, 8'h55, 1, 1);
      rst = 1'b0;
      chk("rst_full_count", int'(bus.count), 0);
      chk("rst_full_valid", int'(bus.rd_valid), 0);

      // Random traffic with a reset in the middle.
      for (int n = 0; n < 600; n++) begin
         if (n == 300) begin
            rst = 1'b1;
            cyc(1, 8'($urandom), 1'($urandom), 1'($urandom));
            rst = 1'b0;
            chk("mid_rst_count", int'(bus.count), 0);
            chk("mid_rst_valid", int'(bus.rd_valid), 0);
         end
         cyc(($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom),
             ($urandom_range(0, 99) < 5));
      end

      cmp_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set the number of byte entries; legal values are powers of two from 2 to 256.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 rx_data  input  8  SHALL carry the received byte from the UART receiver.
REQ-005 rx_done  input  1  SHALL be a one-cycle write strobe; rx_data is valid in that cycle.
REQ-006 rd_data  output  8  SHALL present the head-of-queue byte, show-ahead.
REQ-007 rd_valid  output  1  SHALL be high while the FIFO holds at least one byte.
REQ-008 rd_ready  input  1  SHALL pop the head byte when high in a cycle where rd_valid is high.
REQ-009 count  output  $clog2(DEPTH)+1  SHALL give the number of stored bytes, 0..DEPTH.
REQ-010 overrun  output  1  SHALL be a sticky flag indicating a received byte was dropped.
REQ-011 overrun_clr  input  1  SHALL clear overrun on the next edge.

Function
REQ-012 Write: when rx_done=1 and the FIFO is accepting, rx_data SHALL be stored at the tail and count SHALL increment.
REQ-013 Accepting: count<DEPTH, or count=DEPTH with rd_valid&rd_ready in the same cycle (pop frees the slot).
REQ-014 Write to empty: rd_valid SHALL rise and rd_data SHALL show the byte on the edge after the rx_done cycle (latency 1).
REQ-015 Pop: rd_valid&rd_ready SHALL advance the head on the edge; the next byte appears on rd_data in the following cycle, or rd_valid falls if the FIFO empties.
REQ-016 rd_ready with rd_valid=0 SHALL be ignored; no pointer or count change.
REQ-017 Simultaneous write and pop SHALL leave count unchanged and preserve byte order.
REQ-018 rx_done with the FIFO not accepting SHALL drop the byte, leave contents and count unchanged, and set overrun.
REQ-019 overrun_clr and a new drop in the same cycle: set SHALL win, so overrun stays 1.
REQ-020 Pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH with no bubble at wrap-around.
REQ-021 count SHALL never exceed DEPTH or underflow below 0.
REQ-022 rd_data SHALL hold stable while rd_valid=1 and rd_ready=0.
REQ-023 Output order SHALL equal the rx_done write order.

Reset
REQ-024 rst SHALL set the head and tail pointers to 0, count=0, rd_valid=0, rd_data=8'h00, and overrun=0.
REQ-025 rst asserted mid-operation SHALL discard all stored bytes.
REQ-026 rx_done, rd_ready and overrun_clr SHALL be ignored in any cycle where rst=1.
REQ-027 The storage array SHALL need no reset.

Structure
REQ-028 uart_pkg SHALL hold UART_DATA_W=8 and UART_RX_FIFO_DEPTH=16; uart_rx_fifo SHALL use them as defaults.
REQ-029 The block SHALL be a single module with no sub-module, storage as an inferred register array.
REQ-030 Full and empty SHALL derive from count, not from pointer comparison alone.

Verification
REQ-031 Reset, then 3 writes A5, 3C, FF, then rd_ready=1 -> rd_data sequence A5, 3C, FF; count 3->0; rd_valid falls after the third pop.
REQ-032 16 writes 00..0F with no reads, then a 17th write 99 -> count=16, overrun=1, 99 never appears; reads return 00..0F.
REQ-033 Full FIFO, rx_done=1 (byte 77) with rd_valid&rd_ready in the same cycle -> count stays 16, overrun=0, 77 is read last.
REQ-034 count=1 (byte 11), simultaneous write 22 and pop -> count=1 and next rd_data=22.
REQ-035 overrun=1, overrun_clr=1 in the same cycle as a dropped write -> overrun=1; overrun_clr alone next cycle -> overrun=0.
REQ-036 40 writes interleaved with random rd_ready -> byte order matches a scoreboard through multiple pointer wraps; rst mid-stream -> count=0 and rd_valid=0 on the next cycle.
